// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between two requesters and
// frames each message as SYNC, byte count, escaped payload, END.
// Ports:
//   clk, reset            clock, async active-high reset
//   req[1:0]              per-requester level request, held until done
//   req_msg[63:0]         payload, requester k in [32k+31:32k], byte 0 on top
//   req_len[5:0]          payload length, requester k in [3k+2:3k]
//   gnt[1:0], done[1:0]   one-hot grant, one-cycle completion pulse
//   err                   one-cycle pulse on timeout abort
//   busy, tx_enable       high whenever the FSM is not idle
//   tx_data, ld_tx_data   byte and load strobe to the uart
//   tx_empty              uart holding register empty
module uart_tx_scheduler #(
    parameter int         MSGBYTES   = 4,
    parameter logic [7:0] SP_SYNC    = 8'h7E,
    parameter logic [7:0] SP_ESC     = 8'hFE,
    parameter logic [7:0] SP_END     = 8'h03,
    parameter int         TX_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [63:0] req_msg,
    input  logic [5:0]  req_len,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic        err,
    output logic        busy,
    output logic [7:0]  tx_data,
    output logic        ld_tx_data,
    output logic        tx_enable,
    input  logic        tx_empty
);

    typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_BUSY, WAIT_EMPTY} state_t;
    typedef enum logic [1:0] {HEAD, BCNT, BODY, TAIL} phase_t;

    localparam logic [2:0]  MAXLEN = 3'(MSGBYTES);
    localparam logic [15:0] TO_LIM = 16'(TX_TIMEOUT);

    state_t      state_q;
    phase_t      phase_q;
    logic [31:0] msg_q;
    logic [2:0]  len_q;
    logic [2:0]  idx_q;
    logic        esc_q;
    logic        k_q;
    logic        last_q;
    logic [15:0] cnt_q;
    logic [1:0]  gnt_q;
    logic [1:0]  done_q;
    logic        err_q;
    logic [7:0]  tx_data_q;
    logic        ld_q;

    logic        sel_d;
    logic [2:0]  raw_len;
    logic [2:0]  len_d;
    logic [31:0] msg_sh;
    logic [7:0]  byte_d;
    logic        esc_d;
    logic [1:0]  fin_oh;

    always_comb begin
        // Contention goes to whoever was not served last.
        if (req[0] && req[1]) sel_d = ~last_q;
        else                  sel_d = req[1];
        raw_len = sel_d ? req_len[5:3] : req_len[2:0];
        len_d   = (raw_len > MAXLEN) ? MAXLEN : raw_len;
        msg_sh  = msg_q << {idx_q[1:0], 3'b000};
        byte_d  = SP_SYNC;
        case (phase_q)
            HEAD: byte_d = SP_SYNC;
            BCNT: byte_d = {5'b0, len_q};
            BODY: byte_d = msg_sh[31:24];
            TAIL: byte_d = SP_END;
        endcase
        // A clear flag means this byte still needs its escape prefix.
        esc_d = (phase_q == BCNT || phase_q == BODY) && !esc_q &&
                (byte_d == SP_SYNC || byte_d == SP_ESC);
        fin_oh = k_q ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= HEAD;
            msg_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            esc_q     <= 1'b0;
            k_q       <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            tx_data_q <= '0;
            ld_q      <= 1'b0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            ld_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Skip the done cycle so a requester can drop req.
                    if (|req && ~|done_q) begin
                        k_q     <= sel_d;
                        msg_q   <= sel_d ? req_msg[63:32] : req_msg[31:0];
                        len_q   <= len_d;
                        idx_q   <= '0;
                        esc_q   <= 1'b0;
                        phase_q <= HEAD;
                        gnt_q   <= sel_d ? 2'b10 : 2'b01;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (tx_empty) begin
                        tx_data_q <= esc_d ? SP_ESC : byte_d;
                        esc_q     <= esc_d;
                        state_q   <= STROBE;
                    end
                end
                STROBE: begin
                    ld_q    <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!tx_empty) begin
                        cnt_q   <= '0;
                        state_q <= WAIT_EMPTY;
                    end else if (cnt_q >= TO_LIM) begin
                        err_q   <= 1'b1;
                        done_q  <= fin_oh;
                        gnt_q   <= '0;
                        last_q  <= k_q;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                WAIT_EMPTY: begin
                    if (tx_empty) begin
                        state_q <= LOAD;
                        if (!esc_q) begin
                            case (phase_q)
                                HEAD: phase_q <= BCNT;
                                BCNT: phase_q <= (len_q == 3'd0) ? TAIL : BODY;
                                BODY: begin
                                    idx_q <= idx_q + 3'd1;
                                    if (idx_q + 3'd1 == len_q) phase_q <= TAIL;
                                end
                                TAIL: begin
                                    done_q  <= fin_oh;
                                    gnt_q   <= '0;
                                    last_q  <= k_q;
                                    state_q <= IDLE;
                                end
                            endcase
                        end
                    end else if (cnt_q >= TO_LIM) begin
                        err_q   <= 1'b1;
                        done_q  <= fin_oh;
                        gnt_q   <= '0;
                        last_q  <= k_q;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = (state_q != IDLE);
    assign tx_enable  = busy;
    assign tx_data    = tx_data_q;
    assign ld_tx_data = ld_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed bench with a uart model and a byte
// scoreboard for uart_tx_scheduler.
module tb_uart_tx_scheduler;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [63:0] req_msg;
    logic [5:0]  req_len;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        err;
    logic        busy;
    logic [7:0]  tx_data;
    logic        ld_tx_data;
    logic        tx_enable;
    logic        tx_empty = 1'b1;

    uart_tx_scheduler #(.TX_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_msg(req_msg),
        .req_len(req_len), .gnt(gnt), .done(done), .err(err),
        .busy(busy), .tx_data(tx_data), .ld_tx_data(ld_tx_data),
        .tx_enable(tx_enable), .tx_empty(tx_empty)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    logic [31:0] exp_q[$];
    int ld_cnt = 0;
    int err_cnt = 0;
    int dcnt[2] = '{0, 0};
    int cyc = 0;
    int ld_cyc = 0;
    int err_cyc = 0;
    int ubusy = 0;
    bit stuck = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // uart model and scoreboard consumer, all on the falling edge
    always @(negedge clk) begin
        logic [31:0] e;
        cyc++;
        if (reset) begin
            tx_empty = 1'b1;
            ubusy = 0;
        end else begin
            if (done[0]) dcnt[0]++;
            if (done[1]) dcnt[1]++;
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (ld_tx_data) begin
                ld_cnt++;
                ld_cyc = cyc;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                chk("tx_byte", 32'(tx_data), e);
                if (!stuck) begin
                    tx_empty = 1'b0;
                    ubusy = 10;
                end
            end else if (ubusy > 0) begin
                ubusy--;
                if (ubusy == 0) tx_empty = 1'b1;
            end
        end
    end

    task automatic push_b(input logic [7:0] b, input bit esc);
        if (esc && (b == 8'h7E || b == 8'hFE)) exp_q.push_back(32'hFE);
        exp_q.push_back(32'(b));
    endtask

    task automatic push_frame(input logic [31:0] msg, input logic [2:0] len);
        logic [2:0] l;
        logic [31:0] m;
        l = (len > 3'd4) ? 3'd4 : len;
        m = msg;
        push_b(8'h7E, 1'b0);
        push_b({5'b0, l}, 1'b1);
        for (int i = 0; i < int'(l); i++) begin
            push_b(m[31:24], 1'b1);
            m = m << 8;
        end
        push_b(8'h03, 1'b0);
    endtask

    task automatic set_req(input int k, input logic [31:0] msg,
                           input logic [2:0] len);
        if (k == 1) begin
            req_msg[63:32] = msg;
            req_len[5:3] = len;
        end else begin
            req_msg[31:0] = msg;
            req_len[2:0] = len;
        end
    endtask

    task automatic wait_done(input int k, input int maxc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (done[k]) seen = 1'b1;
        end
    endtask

    task automatic run_req(input int k, input logic [31:0] msg,
                           input logic [2:0] len, input string tag);
        int d0;
        bit seen;
        bit gok;
        logic [1:0] oh;
        oh = (k == 1) ? 2'b10 : 2'b01;
        set_req(k, msg, len);
        push_frame(msg, len);
        d0 = dcnt[k];
        req[k] = 1'b1;
        @(negedge clk);
        chk({tag, "_gnt"}, 32'(gnt), 32'(oh));
        req_msg = {$urandom, $urandom};
        req_len = 6'($urandom);
        gok = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done[k]) seen = 1'b1;
            else if (gnt !== oh) gok = 1'b0;
        end
        req[k] = 1'b0;
        chk({tag, "_done"}, 32'(seen), 32'd1);
        chk({tag, "_gnt_held"}, 32'(gok), 32'd1);
        repeat (2) @(negedge clk);
        chk({tag, "_done_pulses"}, 32'(dcnt[k] - d0), 32'd1);
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int l0;
        int e0;
        bit seen;
        reset = 1'b1;
        req = '0;
        req_msg = '0;
        req_len = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            32'({gnt, done, err, busy, ld_tx_data, tx_enable, tx_data}), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_req(0, 32'h1234ABCD, 3'd2, "r0_len2");

        l0 = ld_cnt;
        run_req(1, 32'h7EFE0000, 3'd2, "r1_esc");
        chk("r1_esc_ld_count", 32'(ld_cnt - l0), 32'd7);

        // both at once: 0 first after reset, then 1
        set_req(0, 32'hA0A1A2A3, 3'd1);
        set_req(1, 32'hB0B1B2B3, 3'd3);
        push_frame(32'hA0A1A2A3, 3'd1);
        push_frame(32'hB0B1B2B3, 3'd3);
        req = 2'b11;
        @(negedge clk);
        chk("both_first_gnt", 32'(gnt), 32'd1);
        wait_done(0, 3000, seen);
        req[0] = 1'b0;
        chk("both_done0", 32'(seen), 32'd1);
        wait_done(1, 3000, seen);
        req[1] = 1'b0;
        chk("both_done1", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        chk("both_sb_empty", 32'(exp_q.size()), 32'd0);

        // again both: last served was 1, so 0 wins
        set_req(0, 32'hC0C1C2C3, 3'd2);
        set_req(1, 32'hD0D1D2D3, 3'd1);
        push_frame(32'hC0C1C2C3, 3'd2);
        push_frame(32'hD0D1D2D3, 3'd1);
        req = 2'b11;
        @(negedge clk);
        chk("rr_gnt", 32'(gnt), 32'd1);
        wait_done(0, 3000, seen);
        req[0] = 1'b0;
        chk("rr_done0", 32'(seen), 32'd1);
        wait_done(1, 3000, seen);
        req[1] = 1'b0;
        chk("rr_done1", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        chk("rr_sb_empty", 32'(exp_q.size()), 32'd0);

        run_req(1, 32'h01020304, 3'd4, "r1_again_a");
        run_req(1, 32'h05060708, 3'd3, "r1_again_b");

        run_req(0, 32'hA1B2C3D4, 3'd6, "len6_clamp");
        run_req(1, 32'h55667788, 3'd0, "len0");

        // uart never goes busy: abort after timeout
        stuck = 1'b1;
        set_req(0, 32'h11111111, 3'd2);
        exp_q.push_back(32'h7E);
        l0 = ld_cnt;
        e0 = err_cnt;
        req[0] = 1'b1;
        wait_done(0, TO + 50, seen);
        req[0] = 1'b0;
        chk("to_done", 32'(seen), 32'd1);
        chk("to_err_now", 32'(err), 32'd1);
        repeat (20) @(negedge clk);
        chk("to_latency", 32'(err_cyc - ld_cyc), 32'(TO + 1));
        chk("to_err_pulses", 32'(err_cnt - e0), 32'd1);
        chk("to_one_strobe", 32'(ld_cnt - l0), 32'd1);
        chk("to_sb_empty", 32'(exp_q.size()), 32'd0);
        stuck = 1'b0;
        run_req(1, 32'h9ABCDEF0, 3'd2, "after_to");

        // reset in the middle of the payload
        set_req(0, 32'h11223344, 3'd4);
        push_frame(32'h11223344, 3'd4);
        l0 = ld_cnt;
        req[0] = 1'b1;
        for (int i = 0; i < 500 && (ld_cnt - l0) < 3; i++) @(negedge clk);
        chk("mid_body_reached", 32'(ld_cnt - l0), 32'd3);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_reset_outputs",
            32'({gnt, done, err, busy, ld_tx_data, tx_enable, tx_data}), 32'd0);
        exp_q.delete();
        req = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run_req(1, 32'hCAFE0102, 3'd3, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Sequences and shares the UART transmitter between two message requesters, for example a command-acknowledge responder and a status reporter.
- Frames each message in the same protocol the RX decoder accepts: SYNC, byte count, payload with escaping, END.
- Sits between the requesters and the uart tx_* port group, on the same clock as the UART tx clock.

Parameters:
- MSGBYTES, 4, maximum payload bytes per message.
- SP_SYNC, 8'h7E, frame start byte.
- SP_ESC, 8'hFE, escape byte.
- SP_END, 8'h03, frame end byte.
- TX_TIMEOUT, 1000, maximum clk cycles spent waiting in either WAIT_BUSY or WAIT_EMPTY before the frame is aborted.

Ports:
- clk  in  1  Single clock for the block.
- reset  in  1  Asynchronous, active-high.
- req  in  2  Per-requester send request; level; held until that requester's done pulse.
- req_msg  in  64  Payload; requester k occupies [32k+31:32k]; byte 0 is bits [32k+31:32k+24].
- req_len  in  6  Payload length; requester k occupies [3k+2:3k].
- gnt  out  2  One-hot; high while a frame for that requester is in flight.
- done  out  2  One-cycle pulse when that requester's frame finishes or is aborted.
- err  out  1  One-cycle pulse on abort by timeout.
- busy  out  1  High in every state except IDLE.
- tx_data  out  8  Byte presented to the uart.
- ld_tx_data  out  1  One-cycle load strobe to the uart.
- tx_enable  out  1  Equals busy.
- tx_empty  in  1  uart transmit-holding-empty flag.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-frame):
  - gnt, done, err, busy, ld_tx_data, tx_enable and tx_data all go to 0.
  - FSM goes to IDLE.
  - The round-robin pointer is set so that requester 0 wins the first contest.
- FSM states: IDLE, LOAD, STROBE, WAIT_BUSY, WAIT_EMPTY.
- Frame phases: HEAD, BCNT, BODY, TAIL.
- IDLE:
  - Acts when any req bit is high.
  - If exactly one bit is high, that requester is selected.
  - If both are high, the requester not served last is selected.
  - On the selection edge: latch req_msg/req_len of the selected requester, clamp the length to MSGBYTES (lengths 5-7 become 4), set the phase to HEAD, set gnt one-hot, go to LOAD.
  - gnt is therefore visible the cycle after req is first sampled.
- Requester inputs after capture: a later change to req_msg or req_len is ignored. A req that drops mid-frame is ignored and the frame completes.
- LOAD:
  - Waits until tx_empty=1.
  - Then registers tx_data:
    - HEAD: SP_SYNC.
    - BCNT: the clamped length.
    - BODY: payload byte[idx].
    - TAIL: SP_END.
  - Escaping applies to BCNT and BODY only. If the byte equals SP_SYNC or SP_ESC and the escape-pending flag is clear, tx_data=SP_ESC and the escape-pending flag is set; the same byte is re-sent on the next LOAD with the flag clear.
  - Then go to STROBE.
- STROBE: ld_tx_data=1 for exactly one cycle with tx_data stable; go to WAIT_BUSY.
- WAIT_BUSY: wait for tx_empty=0, then go to WAIT_EMPTY.
- WAIT_EMPTY: wait for tx_empty=1, then advance:
  - If an escape is pending: stay in the same phase, go to LOAD.
  - HEAD goes to BCNT.
  - BCNT goes to BODY, or to TAIL if the length is 0.
  - BODY increments idx, then goes to TAIL once idx reaches the length.
  - TAIL: pulse done[k], clear gnt, record k as last served, go to IDLE.
- Timing:
  - tx_data changes only in LOAD.
  - Minimum 4 cycles per byte plus the uart's busy time.
  - The first strobe occurs no earlier than 2 cycles after gnt rises.
- Timeout:
  - A 16-bit counter is cleared on entry to WAIT_BUSY and to WAIT_EMPTY.
  - If it exceeds TX_TIMEOUT: pulse err and done[k], clear gnt, go to IDLE without sending further bytes.
  - The round-robin pointer is still updated.
- A new arbitration occurs only in IDLE; there is no back-to-back grant inside the same cycle that done pulses.

Test Plan:
- Req0, len=2, msg=0x1234xxxx, uart model with 10-cycle busy -> tx byte stream 7E 02 12 34 03; done[0] single pulse; gnt[0] high throughout.
- Req1, len=2, payload 7E FE -> stream 7E 02 FE 7E FE FE 03; ld_tx_data pulse count 7.
- Req0 and req1 asserted together after reset and held -> frame 0 then frame 1. Re-assert both -> requester 0 served next. Assert only req1 twice in a row -> served both times.
- len=6 -> BCNT byte 04 and four payload bytes. len=0 -> stream 7E 00 03.
- tx_empty stuck at 1 after the first strobe -> err and done pulse at TX_TIMEOUT+1 cycles into WAIT_BUSY; no further strobes; next req is accepted normally.
- Reset asserted during BODY -> all outputs 0 in the same cycle. After release, req1 alone -> clean full frame.
